nor_bank: RTL

//  Parametrised successor of the single 3-input NOR cell: CHANNELS independent NOR gates of INPUTS

---
 rtl/nor_bank_pkg.sv | 44 ++++
 rtl/nor_bank_delay_line.sv | 50 +++++
 rtl/nor_bank.sv | 113 +++++++++++
 3 files changed

// File: rtl/nor_bank_pkg.sv
// nor_bank_pkg
//   Shared helpers for the nor_bank NOR-gate bank:
//   - nor_reduce : NOR of a zero-extended input vector (zero padding leaves
//                  the NOR result unchanged, so any gate width up to
//                  MAX_INPUTS can share one function).
//   - sat_inc    : increment that sticks at 2^width-1.
//   - params_legal : elaboration-time sanity check of the bank parameters.
package nor_bank_pkg;

  localparam int unsigned MAX_INPUTS = 64;
  localparam int unsigned MAX_CNT_W  = 64;

  function automatic logic nor_reduce(input logic [MAX_INPUTS-1:0] vec);
    return ~|vec;
  endfunction

  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input int unsigned width);
    logic [MAX_CNT_W-1:0] top;
    if (width >= MAX_CNT_W) top = '1;
    else                    top = (64'd1 << width) - 64'd1;
    return (val >= top) ? top : val + 64'd1;
  endfunction

  function automatic bit params_legal(input int unsigned channels,
                                      input int unsigned inputs,
                                      input int unsigned delay_cyc,
                                      input int unsigned settle_cyc,
                                      input int unsigned cnt_w,
                                      input int unsigned iv_width);
    bit ok;
    ok = 1'b1;
    if (channels   < 1)          ok = 1'b0;
    if (inputs     < 1)          ok = 1'b0;
    if (inputs     > MAX_INPUTS) ok = 1'b0;
    if (delay_cyc  < 1)          ok = 1'b0;
    if (settle_cyc < 1)          ok = 1'b0;
    if (cnt_w      < 1)          ok = 1'b0;
    if (cnt_w      > MAX_CNT_W)  ok = 1'b0;
    if (iv_width  != channels)   ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/nor_bank_delay_line.sv
// nor_bank_delay_line
//   DELAY_CYC x CHANNELS posedge shift register. The last stage is the
//   registered output of the bank. All stages reset asynchronously to IV and
//   load IV synchronously when load is high.
// Ports
//   clk  : clock (posedge)
//   rst  : asynchronous active-low reset
//   load : synchronous load of IV into every stage
//   din  : sampled NOR values entering the first stage
//   nxt  : value the last stage takes at the coming posedge
//   q    : last stage (bank output)
module nor_bank_delay_line #(
  parameter int unsigned         CHANNELS  = 4,
  parameter int unsigned         DELAY_CYC = 1,
  parameter logic [CHANNELS-1:0] IV        = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] nxt,
  output logic [CHANNELS-1:0] q
);

  logic [CHANNELS-1:0] stage [DELAY_CYC];
  logic [CHANNELS-1:0] feed;

  // Input of the last stage: din itself for a single stage, otherwise the
  // stage just ahead of it.
  if (DELAY_CYC == 1) begin : g_single
    assign feed = din;
  end else begin : g_multi
    assign feed = stage[DELAY_CYC-2];
  end

  assign nxt = load ? IV : feed;
  assign q   = stage[DELAY_CYC-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < DELAY_CYC; k++) stage[k] <= IV;
    end else if (load) begin
      for (int unsigned k = 0; k < DELAY_CYC; k++) stage[k] <= IV;
    end else begin
      stage[0] <= din;
      for (int unsigned k = 1; k < DELAY_CYC; k++) stage[k] <= stage[k-1];
    end
  end

endmodule

// File: rtl/nor_bank.sv
// nor_bank
//   CHANNELS independent INPUTS-input NOR gates in the two-phase FPGA style:
//   inputs are sampled on the falling edge, outputs advance on the rising
//   edge through a DELAY_CYC-stage pipeline. Adds hold (en), force-to-IV,
//   a settle detector and a saturating output-toggle counter.
// Ports
//   clk      : clock; negedge samples, posedge updates
//   rst      : asynchronous active-low reset
//   en       : 1 = sample inputs at negedge, 0 = hold last sample
//   force_iv : synchronous load of IV into sample, pipeline and y
//   cnt_clr  : synchronous clear of tog_cnt (wins over increment)
//   a        : channel i inputs = a[i*INPUTS +: INPUTS]
//   y        : y[i] = delayed NOR of channel i inputs (flop output)
//   settled  : y unchanged for >= SETTLE_CYC consecutive posedges
//   tog_cnt  : saturating count of posedges on which any y bit changed
module nor_bank
  import nor_bank_pkg::*;
#(
  parameter int unsigned         CHANNELS   = 4,
  parameter int unsigned         INPUTS     = 3,
  parameter int unsigned         DELAY_CYC  = 1,
  parameter logic [CHANNELS-1:0] IV         = '0,
  parameter int unsigned         SETTLE_CYC = 4,
  parameter int unsigned         CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       force_iv,
  input  logic                       cnt_clr,
  input  logic [CHANNELS*INPUTS-1:0] a,
  output logic [CHANNELS-1:0]        y,
  output logic                       settled,
  output logic [CNT_W-1:0]           tog_cnt
);

  if (!params_legal(CHANNELS, INPUTS, DELAY_CYC, SETTLE_CYC, CNT_W, $bits(IV))) begin : g_param_error
    $error("nor_bank: illegal parameter combination");
  end

  localparam int unsigned STABLE_W = $clog2(SETTLE_CYC + 1);

  logic [CHANNELS-1:0] nor_now;
  logic [CHANNELS-1:0] smp;
  logic [CHANNELS-1:0] y_nxt;
  logic                y_moves;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_nxt;

  always_comb begin
    nor_now = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      nor_now[i] = nor_reduce(MAX_INPUTS'(a[i*INPUTS +: INPUTS]));
    end
  end

  // Falling-edge sample stage.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      smp <= IV;
    end else if (force_iv) begin
      smp <= IV;
    end else if (en) begin
      smp <= nor_now;
    end
  end

  nor_bank_delay_line #(
    .CHANNELS (CHANNELS),
    .DELAY_CYC(DELAY_CYC),
    .IV       (IV)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .load(force_iv),
    .din (smp),
    .nxt (y_nxt),
    .q   (y)
  );

  // Settle/toggle decisions look at the value y is about to take, so both
  // react on the same posedge that y changes.
  assign y_moves = (y_nxt != y);

  always_comb begin
    stable_nxt = '0;
    if (!force_iv && !y_moves) begin
      if (stable_cnt >= STABLE_W'(SETTLE_CYC)) stable_nxt = STABLE_W'(SETTLE_CYC);
      else                                     stable_nxt = stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_cnt <= '0;
      settled    <= 1'b0;
    end else begin
      stable_cnt <= stable_nxt;
      settled    <= (stable_nxt >= STABLE_W'(SETTLE_CYC));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_cnt <= '0;
    end else if (cnt_clr) begin
      tog_cnt <= '0;
    end else if (y_moves) begin
      tog_cnt <= CNT_W'(sat_inc(MAX_CNT_W'(tog_cnt), CNT_W));
    end
  end

endmodule
